cpu_sequencer: RTL and testbench

Multi-cycle control state machine for the ELVM CPU datapath. It owns the program counter, sequences fetch/decode/execute/memory phases, and issues register-file write, data-memory read/write and ROM fetch strobes. It also stalls `putc` on a valid/ready handshake toward the character output, and freezes the core on `exit`. It replaces free-running single-cycle execution, so the ROM, the data memory and the output sink each see one well-defined access per phase.

---
 rtl/cpu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the ELVM CPU: owns the PC, steps
// FETCH/DECODE/EXEC/MEM/PUTC/HALT and issues registered one-cycle strobes.
module cpu_sequencer #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned IM_W   = 24,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [4:0]        op,
   input  logic              is_sorce_im,
   input  logic [IM_W-1:0]   im,
   input  logic              cond_true,
   input  logic              putc_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              ir_load,
   output logic              reg_we,
   output logic              mem_re,
   output logic              mem_we,
   output logic              putc_valid,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_PUTC   = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_STORE, C_PUTC, C_EXIT, C_CJMP, C_JMP, C_NOP
   } op_class_e;

   function automatic op_class_e classify(input logic [4:0] o);
      op_class_e c;
      case (o) inside
         5'd0, 5'd1, 5'd2, [5'd8:5'd13]: c = C_ALU;
         5'd3:                           c = C_LOAD;
         5'd4:                           c = C_STORE;
         5'd5:                           c = C_PUTC;
         5'd6:                           c = C_EXIT;
         [5'd14:5'd19]:                  c = C_CJMP;
         5'd20:                          c = C_JMP;
         default:                        c = C_NOP;
      endcase
      return c;
   endfunction

   state_e              state_q, state_d;
   op_class_e           cls_q, cls_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                ir_load_q, ir_load_d;
   logic                reg_we_q, reg_we_d;
   logic                mem_re_q, mem_re_d;
   logic                mem_we_q, mem_we_d;
   logic                putc_valid_q, putc_valid_d;
   logic                halted_q, halted_d;

   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   jmp_target;
   logic [CNT_W-1:0]    retired_inc;
   logic                unused_inputs;

   assign pc_inc        = pc_q + ADDR_W'(1);
   assign jmp_target    = im[ADDR_W-1:0];
   assign retired_inc   = retired_q + CNT_W'(1);
   assign unused_inputs = ^{is_sorce_im, im[IM_W-1:ADDR_W]};

   // Strobes are computed one state ahead so every output is a flop.
   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      pc_d         = pc_q;
      retired_d    = retired_q;
      ir_load_d    = 1'b0;
      reg_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      putc_valid_d = 1'b0;
      halted_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d   = S_FETCH;
               ir_load_d = 1'b1;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            cls_d   = classify(op);
            state_d = S_EXEC;
            case (classify(op))
               C_ALU:   reg_we_d = 1'b1;
               C_LOAD:  mem_re_d = 1'b1;
               C_STORE: mem_we_d = 1'b1;
               default: ;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_LOAD: begin
                  state_d  = S_MEM;
                  reg_we_d = 1'b1;
               end
               C_PUTC: begin
                  state_d      = S_PUTC;
                  putc_valid_d = 1'b1;
               end
               C_EXIT: begin
                  state_d   = S_HALT;
                  halted_d  = 1'b1;
                  retired_d = retired_inc;
               end
               default: begin
                  state_d   = S_FETCH;
                  ir_load_d = 1'b1;
                  retired_d = retired_inc;
                  if (cls_q == C_JMP || (cls_q == C_CJMP && cond_true))
                     pc_d = jmp_target;
                  else
                     pc_d = pc_inc;
               end
            endcase
         end
         S_MEM: begin
            state_d   = S_FETCH;
            ir_load_d = 1'b1;
            pc_d      = pc_inc;
            retired_d = retired_inc;
         end
         S_PUTC: begin
            if (putc_ready) begin
               state_d   = S_FETCH;
               ir_load_d = 1'b1;
               pc_d      = pc_inc;
               retired_d = retired_inc;
            end else begin
               putc_valid_d = 1'b1;
            end
         end
         S_HALT: halted_d = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cls_q        <= C_NOP;
         pc_q         <= '0;
         retired_q    <= '0;
         ir_load_q    <= 1'b0;
         reg_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         putc_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cls_q        <= cls_d;
         pc_q         <= pc_d;
         retired_q    <= retired_d;
         ir_load_q    <= ir_load_d;
         reg_we_q     <= reg_we_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         putc_valid_q <= putc_valid_d;
         halted_q     <= halted_d;
      end
   end

   assign pc         = pc_q;
   assign ir_load    = ir_load_q;
   assign reg_we     = reg_we_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign putc_valid = putc_valid_q;
   assign halted     = halted_q;
   assign retired    = retired_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model predicts the
// pc/retired/timing/strobe profile of each instruction, a monitor checks it.
module tb_cpu_sequencer;

   localparam int unsigned ABORT = 999;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [4:0]  op = '0;
   logic        is_sorce_im = 1'b0;
   logic [23:0] im = '0;
   logic        cond_true = 1'b0;
   logic        putc_ready = 1'b0;
   logic [7:0]  pc;
   logic        ir_load, reg_we, mem_re, mem_we, putc_valid, halted;
   logic [15:0] retired;
   logic [2:0]  state;

   cpu_sequencer #(.ADDR_W(8), .IM_W(24), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .op(op), .is_sorce_im(is_sorce_im),
      .im(im), .cond_true(cond_true), .putc_ready(putc_ready), .pc(pc),
      .ir_load(ir_load), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
      .putc_valid(putc_valid), .halted(halted), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [23:0] im;
      logic        cond;
      int unsigned k;
   } instr_t;

   // masks: [63:48] reg_we, [47:32] mem_re, [31:16] mem_we, [15:0] putc_valid,
   // bit i = strobe seen in cycle i counted from the FETCH cycle
   typedef struct {
      logic [7:0]  pc;
      logic [15:0] ret;
      int unsigned cyc;
      logic [63:0] masks;
      logic        halt;
   } exp_t;

   instr_t     prog[$];
   exp_t       sb[$];
   logic [7:0] m_pc = '0;
   logic [15:0] m_ret = '0;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input instr_t in);
      exp_t e;
      logic [7:0] nxt;
      e.masks = '0;
      e.halt  = 1'b0;
      e.cyc   = 3;
      nxt     = m_pc + 8'd1;
      if (in.op <= 5'd2 || (in.op >= 5'd8 && in.op <= 5'd13)) e.masks[48+2] = 1'b1;
      else if (in.op == 5'd3) begin
         e.cyc = 4;
         e.masks[32+2] = 1'b1;
         e.masks[48+3] = 1'b1;
      end
      else if (in.op == 5'd4) e.masks[16+2] = 1'b1;
      else if (in.op == 5'd5) begin
         e.cyc = 4 + in.k;
         for (int unsigned j = 0; j <= in.k; j++) e.masks[3+j] = 1'b1;
      end
      else if (in.op == 5'd6) begin
         e.halt = 1'b1;
         nxt    = m_pc;
      end
      else if (in.op >= 5'd14 && in.op <= 5'd19) nxt = in.cond ? in.im[7:0] : m_pc + 8'd1;
      else if (in.op == 5'd20) nxt = in.im[7:0];
      m_ret = m_ret + 16'd1;
      m_pc  = nxt;
      e.pc  = m_pc;
      e.ret = m_ret;
      return e;
   endfunction

   function automatic instr_t mk(input logic [4:0] o, input logic [23:0] i,
                                 input logic c, input int unsigned k);
      instr_t r;
      r.op = o; r.im = i; r.cond = c; r.k = k;
      return r;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({state, pc, retired, ir_load, reg_we, mem_re, mem_we, putc_valid, halted});
   endfunction

   task automatic async_reset(input string nm);
      @(posedge clk);
      #2 rst_n = 1'b0;
      run = 1'b0;
      #1 chk(nm, outs(), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_pc  = '0;
      m_ret = '0;
   endtask

   // Drives the decoder/sink side for the instructions in prog
   task automatic run_prog(output int unsigned run_cycles);
      int unsigned idx = 0, w = 0, cur_k = 0, t = 0;
      bit done = 0;
      instr_t in;
      run_cycles = 0;
      @(negedge clk);
      run = 1'b1;
      while (!done && t < 5000) begin
         @(negedge clk);
         t++;
         if (halted) begin
            run_cycles = t;
            done = 1;
         end else begin
            if (ir_load) begin
               if (idx == prog.size()) begin
                  chk("prog_overrun", 64'(idx), 64'(prog.size() - 1));
                  done = 1;
               end else begin
                  in = prog[idx];
                  idx++;
                  run = 1'($urandom);
                  op = in.op; im = in.im; cond_true = in.cond;
                  is_sorce_im = 1'($urandom);
                  cur_k = in.k;
                  w = 0;
                  if (in.k != ABORT) sb.push_back(model(in));
               end
            end
            if (putc_valid) begin
               if (cur_k == ABORT && w == 3) begin
                  putc_ready = 1'b0;
                  async_reset("reset_in_putc");
                  prog.delete();
                  return;
               end
               putc_ready = (cur_k != ABORT) && (w >= cur_k);
               w++;
            end else begin
               putc_ready = 1'($urandom);
            end
         end
      end
      if (!done) chk("run_timeout", 64'(t), 64'd0);
      prog.delete();
   endtask

   // Monitor: closes an instruction at the next FETCH or at entry to HALT
   initial begin
      int unsigned mcyc = 0;
      logic [63:0] mmask = '0;
      bit in_instr = 0, halt_seen = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_instr = 0;
            halt_seen = 0;
         end else begin
            if (in_instr && (ir_load || (halted && !halt_seen))) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got output pc=0x%0h expected none", pc);
               end else begin
                  e = sb.pop_front();
                  chk("pc", 64'(pc), 64'(e.pc));
                  chk("retired", 64'(retired), 64'(e.ret));
                  chk("cycles", 64'(mcyc), 64'(e.cyc));
                  chk("strobes", mmask, e.masks);
                  chk("halt_state", 64'({halted, state}), 64'({e.halt, e.halt ? 3'd6 : 3'd1}));
               end
            end
            if (halted) begin
               in_instr = 0;
               halt_seen = 1;
            end
            if (ir_load) begin
               in_instr = 1;
               mcyc = 0;
               mmask = '0;
            end
            if (in_instr) begin
               if (mcyc < 16) begin
                  mmask[48+mcyc] = reg_we;
                  mmask[32+mcyc] = mem_re;
                  mmask[16+mcyc] = mem_we;
                  mmask[mcyc]    = putc_valid;
               end
               mcyc++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned cyc;
      logic [4:0] ro;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_hold", 64'({state, ir_load}), 64'd0);
      end

      // mov, add, exit
      prog.push_back(mk(5'd0, 24'h0, 1'b0, 0));
      prog.push_back(mk(5'd1, 24'h0, 1'b0, 0));
      prog.push_back(mk(5'd6, 24'h0, 1'b0, 0));
      run_prog(cyc);
      chk("halt_cycle", 64'(cyc), 64'd10);
      #1 chk("sb_drained_a", 64'(sb.size()), 64'd0);
      repeat (5) begin
         @(negedge clk);
         run = 1'($urandom);
         chk("halt_hold", 64'({state, pc, halted, retired}), 64'({3'd6, m_pc, 1'b1, m_ret}));
      end
      async_reset("reset_in_halt");
      repeat (3) begin
         @(negedge clk);
         chk("idle_after_halt", 64'({state, ir_load}), 64'd0);
      end

      // directed corners followed by random traffic
      prog.push_back(mk(5'd20, 24'hFFFF05, 1'b0, 0));
      prog.push_back(mk(5'd3,  24'h0,      1'b0, 0));
      prog.push_back(mk(5'd15, 24'h0000A3, 1'b1, 0));
      prog.push_back(mk(5'd15, 24'h0000A3, 1'b0, 0));
      prog.push_back(mk(5'd20, 24'hFFFF10, 1'b0, 0));
      prog.push_back(mk(5'd5,  24'h0,      1'b0, 5));
      prog.push_back(mk(5'd5,  24'h0,      1'b0, 0));
      prog.push_back(mk(5'd20, 24'h0000FF, 1'b0, 0));
      prog.push_back(mk(5'd0,  24'h0,      1'b0, 0));
      prog.push_back(mk(5'd31, 24'h0,      1'b0, 0));
      prog.push_back(mk(5'd4,  24'h0,      1'b0, 0));
      for (int i = 0; i < 80; i++) begin
         do ro = 5'($urandom_range(0, 31)); while (ro == 5'd6);
         prog.push_back(mk(ro, 24'($urandom), 1'($urandom), $urandom_range(0, 8)));
      end
      prog.push_back(mk(5'd6, 24'h0, 1'b0, 0));
      run_prog(cyc);
      #1 chk("sb_drained_b", 64'(sb.size()), 64'd0);
      async_reset("reset_after_b");

      // reset while a character is waiting for acceptance
      prog.push_back(mk(5'd0, 24'h0, 1'b0, 0));
      prog.push_back(mk(5'd1, 24'h0, 1'b0, 0));
      prog.push_back(mk(5'd5, 24'h0, 1'b0, ABORT));
      run_prog(cyc);
      #1 chk("sb_drained_c", 64'(sb.size()), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("idle_after_putc_reset", 64'({state, ir_load, putc_valid}), 64'd0);
      end

      prog.push_back(mk(5'd4, 24'h0, 1'b0, 0));
      prog.push_back(mk(5'd6, 24'h0, 1'b0, 0));
      run_prog(cyc);
      chk("halt_cycle_d", 64'(cyc), 64'd7);
      #1 chk("sb_drained_d", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
